// File: rtl/sample_scheduler_if.sv
// Decoder, modulator and controller-side signals of the sample scheduler.
interface sample_scheduler_if #(
    parameter int AW = 4
);
    logic          enable;
    logic [15:0]   rate_div;
    logic [7:0]    sample_in;
    logic          sample_valid;
    logic [7:0]    ack_data;
    logic          ack_valid;
    logic [7:0]    sample_out;
    logic          sample_strobe;
    logic [7:0]    data_tx;
    logic          tx;
    logic [AW:0]   level;
    logic          underrun;
    logic          overflow;

    modport master (
        output enable, rate_div, sample_in, sample_valid, ack_data, ack_valid,
        input  sample_out, sample_strobe, data_tx, tx, level, underrun, overflow
    );

    modport slave (
        input  enable, rate_div, sample_in, sample_valid, ack_data, ack_valid,
        output sample_out, sample_strobe, data_tx, tx, level, underrun, overflow
    );
endinterface

// File: rtl/sample_scheduler.sv
// Buffers decoder samples and releases one every rate_div clocks (registered, 1-cycle after tick);
// no backpressure on writes (full drops and flags overflow), host throttled by XOFF/XON bytes.
module sample_scheduler #(
    parameter int         AW        = 4,
    parameter int         HIGH_MARK = 12,
    parameter int         LOW_MARK  = 4,
    parameter logic [7:0] XOFF_BYTE = 8'h13,
    parameter logic [7:0] XON_BYTE  = 8'h11
) (
    input  logic              clk,
    input  logic              rst,
    sample_scheduler_if.slave bus
);
    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_PREFILL = 2'd1;
    localparam logic [1:0]  ST_RUN     = 2'd2;
    localparam logic [AW:0] FULL_LVL   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] HI_LVL     = HIGH_MARK[AW:0];
    localparam logic [AW:0] LO_LVL     = LOW_MARK[AW:0];

    logic [1:0]    state;
    logic [15:0]   cnt;
    logic [15:0]   div_q;
    logic [7:0]    mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          xoff_sent;
    logic          pend_vld;
    logic [7:0]    pend_byte;
    logic [7:0]    sample_out_q;
    logic          strobe_q;
    logic [7:0]    data_tx_q;
    logic          tx_q;
    logic          underrun_q;
    logic          overflow_q;

    logic [15:0]   div_eff;
    logic          empty;
    logic          full;
    logic          tick;
    logic          pop;
    logic          push;
    logic [AW:0]   count_nxt;
    logic          flow_vld;
    logic [7:0]    flow_byte;
    logic          xoff_nxt;
    logic          pend_vld_eff;
    logic [7:0]    pend_byte_eff;

    assign div_eff = (bus.rate_div < 16'd2) ? 16'd1 : bus.rate_div;

    always_comb begin
        empty     = (count == '0);
        full      = (count == FULL_LVL);
        tick      = bus.enable && (state == ST_RUN) && (cnt == div_q - 16'd1);
        pop       = tick && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
        push      = bus.enable && (state != ST_IDLE) && bus.sample_valid && (!full || pop);
        count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

        flow_vld  = 1'b0;
        flow_byte = XON_BYTE;
        xoff_nxt  = xoff_sent;
        if (!bus.enable) begin
            if (xoff_sent) begin
                flow_vld = 1'b1;
                xoff_nxt = 1'b0;
            end
        end else if (count_nxt >= HI_LVL && !xoff_sent) begin
            flow_vld  = 1'b1;
            flow_byte = XOFF_BYTE;
            xoff_nxt  = 1'b1;
        end else if (count_nxt <= LO_LVL && xoff_sent) begin
            flow_vld = 1'b1;
            xoff_nxt = 1'b0;
        end

        // A fresh request replaces any unsent one; it may also go out this very cycle.
        pend_vld_eff  = flow_vld | pend_vld;
        pend_byte_eff = flow_vld ? flow_byte : pend_byte;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.sample_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            div_q        <= 16'd1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            xoff_sent    <= 1'b0;
            pend_vld     <= 1'b0;
            pend_byte    <= '0;
            sample_out_q <= '0;
            strobe_q     <= 1'b0;
            data_tx_q    <= '0;
            tx_q         <= 1'b0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            strobe_q  <= 1'b0;
            xoff_sent <= xoff_nxt;
            pend_byte <= pend_byte_eff;
            pend_vld  <= pend_vld_eff & bus.ack_valid;
            tx_q      <= bus.ack_valid | pend_vld_eff;
            if (bus.ack_valid) begin
                data_tx_q <= bus.ack_data;
            end else if (pend_vld_eff) begin
                data_tx_q <= pend_byte_eff;
            end

            if (!bus.enable) begin
                state      <= ST_IDLE;
                cnt        <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                underrun_q <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                count <= count_nxt;
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) begin
                    rd_ptr       <= rd_ptr + AW'(1);
                    sample_out_q <= mem[rd_ptr];
                    strobe_q     <= 1'b1;
                end
                if (bus.sample_valid && (state != ST_IDLE) && !push) overflow_q <= 1'b1;

                case (state)
                    ST_IDLE: begin
                        state <= ST_PREFILL;
                        cnt   <= '0;
                        div_q <= div_eff;
                    end
                    ST_PREFILL: begin
                        cnt   <= '0;
                        div_q <= div_eff;
                        if (count >= LO_LVL) state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (tick) begin
                            // New divider is only picked up on a wrap.
                            cnt   <= '0;
                            div_q <= div_eff;
                            if (empty) begin
                                underrun_q <= 1'b1;
                                state      <= ST_PREFILL;
                            end
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.sample_out    = sample_out_q;
    assign bus.sample_strobe = strobe_q;
    assign bus.data_tx       = data_tx_q;
    assign bus.tx            = tx_q;
    assign bus.level         = count;
    assign bus.underrun      = underrun_q;
    assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_sample_scheduler.sv
// Bench for sample_scheduler: directed table, corner sequences, and random traffic vs a queue model.
module tb_sample_scheduler;
    localparam int AW = 4;
    localparam logic [7:0] XOFF = 8'h13;
    localparam logic [7:0] XON  = 8'h11;
    localparam int S_IDLE = 0, S_PREFILL = 1, S_RUN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sample_scheduler_if #(.AW(AW)) bus ();
    sample_scheduler #(.AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passed = 0;

    // Reference model: FIFO as a queue, scheduler as plain integers.
    logic [7:0] q[$];
    int         m_state, m_cnt, m_div;
    logic [7:0] m_out, m_dtx, m_pbyte;
    bit         m_strobe, m_tx, m_under, m_over, m_xoff, m_pvld;

    typedef struct {
        bit          en;
        logic [15:0] rd;
        bit          sv;
        logic [7:0]  sin;
        bit          stb;
        logic [7:0]  out;
        logic [4:0]  lvl;
        bit          und;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_state = S_IDLE; m_cnt = 0; m_div = 1;
        m_out = 0; m_dtx = 0; m_pbyte = 0;
        m_strobe = 0; m_tx = 0; m_under = 0; m_over = 0; m_xoff = 0; m_pvld = 0;
    endtask

    task automatic model_step();
        int old, dnew;
        bit tick, pop, wr_ok, req;
        logic [7:0] rb;
        old = q.size();
        dnew = (bus.rate_div <= 16'd1) ? 1 : int'(bus.rate_div);
        m_strobe = 0; req = 0; rb = 0; wr_ok = 0;
        if (!bus.enable) begin
            q.delete();
            m_state = S_IDLE; m_cnt = 0; m_under = 0; m_over = 0;
            if (m_xoff) begin req = 1; rb = XON; m_xoff = 0; end
        end else begin
            tick = (m_state == S_RUN) && (m_cnt == m_div - 1);
            pop  = tick && (old > 0);
            if (bus.sample_valid && m_state != S_IDLE) begin
                if (old < 16 || pop) wr_ok = 1;
                else m_over = 1;
            end
            if (pop) begin m_out = q.pop_front(); m_strobe = 1; end
            if (wr_ok) q.push_back(bus.sample_in);
            case (m_state)
                S_IDLE: begin m_state = S_PREFILL; m_cnt = 0; m_div = dnew; end
                S_PREFILL: begin
                    m_cnt = 0; m_div = dnew;
                    if (old >= 4) m_state = S_RUN;
                end
                default: begin
                    if (tick) begin
                        m_cnt = 0; m_div = dnew;
                        if (old == 0) begin m_under = 1; m_state = S_PREFILL; end
                    end else m_cnt++;
                end
            endcase
            if (q.size() >= 12 && !m_xoff) begin req = 1; rb = XOFF; m_xoff = 1; end
            else if (q.size() <= 4 && m_xoff) begin req = 1; rb = XON; m_xoff = 0; end
        end
        if (req) begin m_pvld = 1; m_pbyte = rb; end
        m_tx = 0;
        if (bus.ack_valid) begin m_tx = 1; m_dtx = bus.ack_data; end
        else if (m_pvld) begin m_tx = 1; m_dtx = m_pbyte; m_pvld = 0; end
    endtask

    task automatic compare_model();
        logic [31:0] act, exp;
        act = {7'd0, bus.sample_out, bus.sample_strobe, bus.data_tx, bus.tx, bus.level, bus.underrun, bus.overflow};
        exp = {7'd0, m_out, m_strobe, m_dtx, m_tx, 5'(q.size()), m_under, m_over};
        check($sformatf("model@%0t", $time), act, exp);
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sample_out"}, 32'(bus.sample_out), 0);
        check({tag, "_strobe"},     32'(bus.sample_strobe), 0);
        check({tag, "_data_tx"},    32'(bus.data_tx), 0);
        check({tag, "_tx"},         32'(bus.tx), 0);
        check({tag, "_level"},      32'(bus.level), 0);
        check({tag, "_underrun"},   32'(bus.underrun), 0);
        check({tag, "_overflow"},   32'(bus.overflow), 0);
    endtask

    task automatic add(input bit sv, input logic [7:0] sin, input bit stb,
                       input logic [7:0] out, input logic [4:0] lvl, input bit und);
        vec_t v;
        v.en = 1; v.rd = 16'd4; v.sv = sv; v.sin = sin;
        v.stb = stb; v.out = out; v.lvl = lvl; v.und = und;
        tbl.push_back(v);
    endtask

    initial begin
        int n, ntx, wp;
        bit seen;
        logic [7:0] tx_byte;
        logic [4:0] tx_lvl;
        logic [7:0] got[$];

        bus.enable = 0; bus.rate_div = 0; bus.sample_in = 0; bus.sample_valid = 0;
        bus.ack_data = 0; bus.ack_valid = 0;
        model_reset();

        // Rate 4, four samples: strobes every 4 clocks, then underrun.
        add(0, 8'h00, 0, 8'h00, 5'd0, 0);
        for (int i = 0; i < 4; i++) add(1, 8'h10 + 8'(i), 0, 8'h00, 5'(i + 1), 0);
        for (int i = 0; i < 4; i++) add(0, 8'h00, 0, 8'h00, 5'd4, 0);
        for (int k = 0; k < 4; k++) begin
            add(0, 8'h00, 1, 8'h10 + 8'(k), 5'(3 - k), 0);
            for (int j = 0; j < 3; j++) add(0, 8'h00, 0, 8'h10 + 8'(k), 5'(3 - k), 0);
        end
        add(0, 8'h00, 0, 8'h13, 5'd0, 1);

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            bus.enable = tbl[i].en; bus.rate_div = tbl[i].rd;
            bus.sample_valid = tbl[i].sv; bus.sample_in = tbl[i].sin;
            tick_cycle();
            check($sformatf("tbl%0d_strobe", i), 32'(bus.sample_strobe), 32'(tbl[i].stb));
            check($sformatf("tbl%0d_out", i),    32'(bus.sample_out),    32'(tbl[i].out));
            check($sformatf("tbl%0d_level", i),  32'(bus.level),         32'(tbl[i].lvl));
            check($sformatf("tbl%0d_under", i),  32'(bus.underrun),      32'(tbl[i].und));
        end
        bus.sample_valid = 0;

        // Eight samples, then divider 0: one strobe per clock once the slow wrap passes.
        bus.rate_div = 16'd1000;
        for (int i = 0; i < 8; i++) begin
            bus.sample_valid = 1; bus.sample_in = 8'h20 + 8'(i);
            tick_cycle();
        end
        bus.sample_valid = 0; bus.rate_div = 16'd0;
        n = 0;
        while (!bus.sample_strobe && n < 2000) begin tick_cycle(); n++; end
        for (int k = 0; k < 8; k++) begin
            check($sformatf("fast%0d_strobe", k), 32'(bus.sample_strobe), 1);
            check($sformatf("fast%0d_out", k),    32'(bus.sample_out), 32'(8'h20 + 8'(k)));
            check($sformatf("fast%0d_level", k),  32'(bus.level), 32'(7 - k));
            tick_cycle();
        end

        // Burst of 17 with slow rate: overflow, single XOFF at level 12, XON at level 4.
        bus.enable = 0; tick_cycle();
        bus.enable = 1; bus.rate_div = 16'd1000; tick_cycle();
        ntx = 0; tx_byte = 0; tx_lvl = 0;
        for (int i = 0; i < 17; i++) begin
            bus.sample_valid = 1; bus.sample_in = 8'h40 + 8'(i);
            tick_cycle();
            if (bus.tx) begin ntx++; tx_byte = bus.data_tx; tx_lvl = bus.level; end
            if (i == 15) begin
                check("burst_level16", 32'(bus.level), 16);
                check("burst_no_ovf_at_16", 32'(bus.overflow), 0);
            end
        end
        bus.sample_valid = 0;
        check("burst_overflow", 32'(bus.overflow), 1);
        check("burst_level", 32'(bus.level), 16);
        check("burst_tx_count", 32'(ntx), 1);
        check("burst_xoff_byte", 32'(tx_byte), 32'(XOFF));
        check("burst_xoff_level", 32'(tx_lvl), 12);
        bus.rate_div = 16'd2;
        n = 0; seen = 0;
        while (!seen && n < 3000) begin
            tick_cycle(); n++;
            if (bus.tx) begin seen = 1; tx_byte = bus.data_tx; tx_lvl = bus.level; end
        end
        check("drain_xon_seen", 32'(seen), 1);
        check("drain_xon_byte", 32'(tx_byte), 32'(XON));
        check("drain_xon_level", 32'(tx_lvl), 4);

        // Full FIFO, write lands on a pop tick: accepted, ordered after the other 15.
        bus.enable = 0; tick_cycle();
        bus.enable = 1; bus.rate_div = 16'd1000; tick_cycle();
        for (int i = 0; i < 16; i++) begin
            bus.sample_valid = 1; bus.sample_in = 8'h60 + 8'(i);
            tick_cycle();
        end
        bus.sample_valid = 0;
        check("full_level", 32'(bus.level), 16);
        n = 0;
        while (!(m_state == S_RUN && m_cnt == m_div - 1) && n < 2000) begin tick_cycle(); n++; end
        bus.sample_valid = 1; bus.sample_in = 8'hEE; bus.rate_div = 16'd1;
        tick_cycle();
        bus.sample_valid = 0;
        check("fullpop_level", 32'(bus.level), 16);
        check("fullpop_overflow", 32'(bus.overflow), 0);
        check("fullpop_strobe", 32'(bus.sample_strobe), 1);
        check("fullpop_out", 32'(bus.sample_out), 32'(8'h60));
        got.delete(); n = 0;
        while (got.size() < 16 && n < 200) begin
            tick_cycle(); n++;
            if (bus.sample_strobe) got.push_back(bus.sample_out);
        end
        check("fullpop_drain_count", 32'(got.size()), 16);
        if (got.size() == 16) begin
            check("fullpop_prev_byte", 32'(got[14]), 32'(8'h6F));
            check("fullpop_new_byte", 32'(got[15]), 32'(8'hEE));
        end

        // Ack collides with the XOFF request: ack first, XOFF next cycle; then disable sends XON.
        bus.enable = 0; tick_cycle();
        bus.enable = 1; bus.rate_div = 16'd1000; tick_cycle();
        for (int i = 0; i < 11; i++) begin
            bus.sample_valid = 1; bus.sample_in = 8'h80 + 8'(i);
            tick_cycle();
        end
        bus.sample_in = 8'h8B; bus.ack_valid = 1; bus.ack_data = 8'h58;
        tick_cycle();
        ntx = int'(bus.tx);
        check("ack_first_tx", 32'(bus.tx), 1);
        check("ack_first_byte", 32'(bus.data_tx), 32'(8'h58));
        check("ack_level", 32'(bus.level), 12);
        bus.sample_valid = 0; bus.ack_valid = 0;
        tick_cycle();
        ntx += int'(bus.tx);
        check("ack_then_xoff_byte", 32'(bus.data_tx), 32'(XOFF));
        tick_cycle();
        ntx += int'(bus.tx);
        check("ack_xoff_pulses", 32'(ntx), 2);
        bus.enable = 0;
        tick_cycle();
        check("dis_level", 32'(bus.level), 0);
        check("dis_underrun", 32'(bus.underrun), 0);
        check("dis_overflow", 32'(bus.overflow), 0);
        check("dis_tx", 32'(bus.tx), 1);
        check("dis_xon_byte", 32'(bus.data_tx), 32'(XON));
        bus.sample_valid = 1; bus.sample_in = 8'hAA;
        tick_cycle();
        check("idle_write_ignored", 32'(bus.level), 0);
        check("idle_no_tx", 32'(bus.tx), 0);
        bus.sample_valid = 0;

        // Random traffic against the model, with an asynchronous reset in the middle.
        wp = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: wp = 30;
                    1: wp = 60;
                    default: wp = 90;
                endcase
                bus.rate_div = 16'($urandom_range(0, 6));
            end
            if (i == 1500) begin
                #2 rst = 1;
                #1;
                check_all_zero("async_rst");
                model_reset();
                @(posedge clk);
                #1 rst = 0;
            end
            bus.enable       = ($urandom_range(0, 199) != 0);
            bus.sample_valid = ($urandom_range(0, 99) < wp);
            bus.sample_in    = 8'($urandom);
            bus.ack_valid    = ($urandom_range(0, 9) == 0);
            bus.ack_data     = 8'($urandom);
            tick_cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
